seg_scan_ctrl: RTL and testbench
================================

# seg_scan_ctrl

Time-multiplexing scheduler for the Basys3 4-digit 7-segment display. It shares the single active-low segment bus between four digits. Frames of four 7-bit character codes, for example the steering-direction characters, are accepted through a valid/ready handshake and applied only at frame boundaries, so the display never tears. It sits between the character-generation logic and the board's `an`/`seg` pins.

## Interface
Parameters:
- `DIGIT_CYCLES`, default 100000: clocks each digit is lit (1 ms at 100 MHz); must be ≥ 1.
- `BLANK_CYCLES`, default 1000: dead-time clocks with all anodes off before each digit (anti-ghosting); must be ≥ 1.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: reset rst, synchronous, active-high; clock clk.
- `en` in 1: scan enable; when low the display is dark.
- `char_in` in 28: frame; digit 3 in [27:21], digit 2 in [20:14], digit 1 in [13:7], digit 0 in [6:0]; active-low segment codes.
- `char_valid` in 1: `char_in` is offered.
- `char_ready` out 1: pending slot empty; a frame is accepted when `char_valid && char_ready`.
- `an` out 4: active-low anodes; `an[i]` drives digit i.
- `seg` out 7: active-low segments.
- `frame_tick` out 1: one-cycle pulse at each frame boundary.

## Operation
- Storage: `active` (28 b, currently displayed) and `pending` (28 b) plus `pend_full`. `char_ready = !pend_full`.
- FSM states:
  - IDLE: `an` = 4'hF, `seg` = 7'h7F.
  - BLANK: `an` = 4'hF, `seg` = 7'h7F.
  - SHOW: `an` has one bit low for digit `idx`; `seg` = `active` slice `idx`.
- Transitions:
  - IDLE→BLANK when `en` = 1.
  - BLANK→SHOW after `BLANK_CYCLES`.
  - SHOW→BLANK after `DIGIT_CYCLES`, with `idx` incrementing modulo 4 (3 wraps to 0).
  - Any state→IDLE when `en` = 0. This clears `idx` and the cycle counter.
- Frame boundary is the last SHOW cycle of `idx` = 3. On that cycle:
  - If `pend_full`: `active` ← `pending`, `pend_full` ← 0.
  - `frame_tick` = 1 on the following cycle.
- Handshake rules:
  - An accepted frame sets `pend_full` and stores the frame in `pending`.
  - If the accept coincides with a boundary cycle while `pend_full` = 0, the frame goes directly into `active` and `pend_full` stays 0.
  - `char_valid` with `char_ready` low is ignored, with no loss of the stored pending frame; the source must hold the frame.
- `en` low does not affect `pending`, `active` or the handshake; frames may still be accepted while dark.
- `rst` mid-scan:
  - Next cycle is IDLE with all outputs at reset values.
  - `active` ← 28'hFFFFFFF (all blank), `pend_full` ← 0.

## Timing
- All outputs are registered.
- Reset values: `an` = 4'hF, `seg` = 7'h7F, `frame_tick` = 0, `char_ready` = 1.
- After `en` rises (registered at edge t): BLANK spans cycles t+1 … t+`BLANK_CYCLES`, then SHOW digit 0 for `DIGIT_CYCLES`.
- Digit period = `BLANK_CYCLES` + `DIGIT_CYCLES`. Frame period = 4 × that.
- A frame accepted at cycle c appears on `seg` at the first SHOW cycle of digit 0 after the next boundary.
- `char_ready` rises one cycle after the promoting boundary.
- Anode and segment changes occur only on the BLANK↔SHOW edge, never mid-digit.
- Counter width is `$clog2(max(DIGIT_CYCLES, BLANK_CYCLES))`, saturating-free, reloaded at each state entry.

## Structure
- Shared package `seg_pkg` holds:
  - Typedef `scan_state_t` (IDLE, BLANK, SHOW).
  - Character constants: D = 7'b0100001, N = 7'b0101011, R = 7'b0101111, BLANK = 7'b1111111.
  - Anode decode constants.
- One natural sub-module, `scan_timer`:
  - Loadable down-counter with `load`, `value` and `done` outputs.
  - Used for both BLANK and SHOW intervals.
- Handshake, storage and FSM live in `seg_scan_ctrl`.

## Test plan
All scenarios use `DIGIT_CYCLES` = 8 and `BLANK_CYCLES` = 2.
- Reset then `en` = 1, no frames:
  - `an` = F for 2 cycles, then `an` = E with `seg` = 7F for 8 cycles.
  - Sequence continues D, B, 7; `frame_tick` every 40 cycles.
- Send `char_in` = {D, N, R, BLANK} once:
  - `char_ready` drops the next cycle.
  - After the boundary, digit 3 shows 7'b0100001, digit 2 7'b0101011, digit 1 7'b0101111, digit 0 7'h7F.
  - `char_ready` = 1 again.
- Hold `char_valid` with a second frame while `pend_full` = 1:
  - No accept until the boundary.
  - The first frame is displayed for one full frame, the second on the next frame; neither is lost.
- Assert valid exactly on the boundary cycle with pending empty:
  - The frame is shown from the immediately following digit 0, with `char_ready` staying 1.
- Drop `en` mid-SHOW of digit 2:
  - Next cycle `an` = F and `seg` = 7F.
  - On re-enable, the scan restarts with BLANK then digit 0, showing unchanged `active` contents.
- Assert `rst` mid-SHOW with `pend_full` = 1:
  - Next cycle all outputs are at reset values, `char_ready` = 1.
  - After re-enable every digit shows 7'h7F.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared types and constants for the 4-digit 7-segment scan controller.
package seg_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BLANK = 2'd1,
      ST_SHOW  = 2'd2
   } scan_state_t;

   // Active-low segment codes for the steering-direction characters.
   localparam logic [6:0] CH_D     = 7'b0100001;
   localparam logic [6:0] CH_N     = 7'b0101011;
   localparam logic [6:0] CH_R     = 7'b0101111;
   localparam logic [6:0] CH_BLANK = 7'b1111111;

   localparam logic [27:0] FRAME_BLANK = {4{CH_BLANK}};

   // Active-low anode patterns: all off, and one digit lit.
   localparam logic [3:0] AN_OFF  = 4'hF;
   localparam logic [3:0] AN_DIG0 = 4'hE;
   localparam logic [3:0] AN_DIG1 = 4'hD;
   localparam logic [3:0] AN_DIG2 = 4'hB;
   localparam logic [3:0] AN_DIG3 = 4'h7;

   function automatic logic [3:0] an_decode(input logic [1:0] idx);
      logic [3:0] an_v;
      case (idx)
         2'd0:    an_v = AN_DIG0;
         2'd1:    an_v = AN_DIG1;
         2'd2:    an_v = AN_DIG2;
         default: an_v = AN_DIG3;
      endcase
      return an_v;
   endfunction

endpackage

// File: rtl/scan_timer.sv
// Loadable down-counter timing the BLANK and SHOW intervals.
// Loading N-1 makes done rise on the Nth cycle after the load.
module scan_timer #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] value,
   output logic         done
);

   logic [W-1:0] cnt;

   // Reload on state entry, otherwise count down and hold at zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= value;
      end else if (cnt != '0) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign done = (cnt == '0);

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan of the Basys3 4-digit 7-segment display.
// Frames arrive over valid/ready into a one-deep pending slot and are
// promoted to the displayed frame only at the frame boundary (last SHOW
// cycle of digit 3), so a frame never tears across digits.
module seg_scan_ctrl
   import seg_pkg::*;
#(
   parameter int DIGIT_CYCLES = 100000,
   parameter int BLANK_CYCLES = 1000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic [27:0] char_in,
   input  logic        char_valid,
   output logic        char_ready,
   output logic [3:0]  an,
   output logic [6:0]  seg,
   output logic        frame_tick
);

   localparam int MAX_CYC = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
   localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
   localparam logic [CNT_W-1:0] DIGIT_LOAD = CNT_W'(DIGIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK_CYCLES - 1);

   scan_state_t      state;
   logic [1:0]       idx;
   logic [27:0]      active;
   logic [27:0]      pending;
   logic             pend_full;

   logic             tmr_load;
   logic [CNT_W-1:0] tmr_value;
   logic             tmr_done;
   logic             blank_end;
   logic             show_end;
   logic             boundary;
   logic             accept;

   scan_timer #(
      .W (CNT_W)
   ) u_timer (
      .clk   (clk),
      .rst   (rst),
      .load  (tmr_load),
      .value (tmr_value),
      .done  (tmr_done)
   );

   assign accept     = char_valid && !pend_full;
   assign char_ready = !pend_full;

   // Interval ends and timer reload; every state entry reloads the timer,
   // and a disabled scan parks the counter at zero.
   always_comb begin
      blank_end = en && (state == ST_BLANK) && tmr_done;
      show_end  = en && (state == ST_SHOW) && tmr_done;
      boundary  = show_end && (idx == 2'd3);
      tmr_load  = 1'b1;
      tmr_value = '0;
      if (!en) begin
         tmr_value = '0;
      end else if (state == ST_IDLE) begin
         tmr_value = BLANK_LOAD;
      end else if (blank_end) begin
         tmr_value = DIGIT_LOAD;
      end else if (show_end) begin
         tmr_value = BLANK_LOAD;
      end else begin
         tmr_load = 1'b0;
      end
   end

   // Scan FSM; an/seg are registered from the next state so they only
   // change on the BLANK/SHOW edges.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         idx        <= 2'd0;
         an         <= AN_OFF;
         seg        <= CH_BLANK;
         frame_tick <= 1'b0;
      end else begin
         frame_tick <= boundary;
         if (!en) begin
            state <= ST_IDLE;
            idx   <= 2'd0;
            an    <= AN_OFF;
            seg   <= CH_BLANK;
         end else begin
            case (state)
               ST_IDLE: begin
                  state <= ST_BLANK;
                  an    <= AN_OFF;
                  seg   <= CH_BLANK;
               end
               ST_BLANK: begin
                  if (tmr_done) begin
                     state <= ST_SHOW;
                     an    <= an_decode(idx);
                     seg   <= active[idx*7 +: 7];
                  end
               end
               ST_SHOW: begin
                  if (tmr_done) begin
                     state <= ST_BLANK;
                     idx   <= idx + 2'd1;
                     an    <= AN_OFF;
                     seg   <= CH_BLANK;
                  end
               end
               default: begin
                  state <= ST_IDLE;
                  idx   <= 2'd0;
                  an    <= AN_OFF;
                  seg   <= CH_BLANK;
               end
            endcase
         end
      end
   end

   // Displayed frame and pending-slot occupancy; an accept on a boundary
   // with the slot empty bypasses the slot straight into the display.
   always_ff @(posedge clk) begin
      if (rst) begin
         active    <= FRAME_BLANK;
         pend_full <= 1'b0;
      end else if (boundary && pend_full) begin
         active    <= pending;
         pend_full <= 1'b0;
      end else if (boundary && accept) begin
         active    <= char_in;
      end else if (accept) begin
         pend_full <= 1'b1;
      end
   end

   // Pending frame capture; pend_full qualifies its contents.
   always_ff @(posedge clk) begin
      if (accept && !boundary) begin
         pending <= char_in;
      end
   end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with DIGIT_CYCLES=8, BLANK_CYCLES=2.
// Every digit lit on the display is checked against a queue of expected
// {an, seg} values pushed by the stimulus ahead of time.
module tb_seg_scan_ctrl;

   localparam logic [6:0] C_D = 7'b0100001;
   localparam logic [6:0] C_N = 7'b0101011;
   localparam logic [6:0] C_R = 7'b0101111;
   localparam logic [6:0] C_B = 7'b1111111;

   logic        clk;
   logic        rst;
   logic        en;
   logic [27:0] char_in;
   logic        char_valid;
   logic        char_ready;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        frame_tick;

   int          n_tests;
   int          n_fail;
   int          k;
   logic [3:0]  prev_an;
   logic [6:0]  prev_seg;
   logic [10:0] exp_q[$];

   seg_scan_ctrl #(
      .DIGIT_CYCLES (8),
      .BLANK_CYCLES (2)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .char_in    (char_in),
      .char_valid (char_valid),
      .char_ready (char_ready),
      .an         (an),
      .seg        (seg),
      .frame_tick (frame_tick)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_tests++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h (k=%0d)", tag, obs, exp_v, k);
      end
   endtask

   task automatic push_digits(input logic [27:0] f, input int ndig);
      logic [3:0] a;
      for (int d = 0; d < ndig; d++) begin
         a = ~(4'b0001 << d);
         exp_q.push_back({a, f[d*7 +: 7]});
      end
   endtask

   // One clock; sample #1 after the edge and score any newly lit digit.
   task automatic tick();
      logic [10:0] e;
      @(posedge clk);
      #1;
      k++;
      if (an !== 4'hF && prev_an === 4'hF) begin
         if (exp_q.size() == 0) begin
            chk("scan_unexpected_digit", 32'({an, seg}), 32'h7FF);
         end else begin
            e = exp_q.pop_front();
            chk("scan_digit", 32'({an, seg}), 32'(e));
         end
      end else if (an !== 4'hF && an === prev_an) begin
         chk("seg_steady", 32'(seg), 32'(prev_seg));
      end
      prev_an  = an;
      prev_seg = seg;
   endtask

   task automatic wait_k(input int target);
      while (k < target) tick();
   endtask

   task automatic enable();
      en = 1'b1;
      k  = -1;
   endtask

   // Offer a frame and hold it until accepted (bounded).
   task automatic send(input logic [27:0] f);
      int w;
      w          = 0;
      char_in    = f;
      char_valid = 1'b1;
      while (char_ready !== 1'b1 && w < 200) begin
         tick();
         w++;
      end
      if (w >= 200) chk("send_timeout", 32'(char_ready), 32'd1);
      tick();
      char_valid = 1'b0;
   endtask

   initial begin
      logic [27:0] f1, fa, fb, fc, fe, fblank;
      logic [3:0]  exp_an;
      n_tests    = 0;
      n_fail     = 0;
      k          = 0;
      prev_an    = 4'hF;
      prev_seg   = 7'h7F;
      rst        = 1'b1;
      en         = 1'b0;
      char_in    = '0;
      char_valid = 1'b0;
      fblank     = {C_B, C_B, C_B, C_B};
      f1         = {C_D, C_N, C_R, C_B};
      fa         = {C_R, C_D, C_N, C_D};
      fb         = {C_N, C_R, C_D, C_B};
      fc         = {C_D, C_D, C_N, C_N};
      fe         = {C_N, C_N, C_R, C_R};

      // Reset values
      tick(); tick(); tick();
      chk("rst_an", 32'(an), 32'h0F);
      chk("rst_seg", 32'(seg), 32'h7F);
      chk("rst_frame_tick", 32'(frame_tick), 32'd0);
      chk("rst_char_ready", 32'(char_ready), 32'd1);
      rst = 1'b0;
      tick();
      chk("idle_an", 32'(an), 32'h0F);

      // Free-running scan, no frames: three blank frames
      push_digits(fblank, 4);
      push_digits(fblank, 4);
      push_digits(fblank, 4);
      enable();
      for (int i = 0; i < 40; i++) begin
         tick();
         exp_an = ((i % 10) < 2) ? 4'hF : ~(4'b0001 << (i / 10));
         chk("scan_an_seq", 32'(an), 32'(exp_an));
         chk("scan_no_tick", 32'(frame_tick), 32'd0);
      end
      tick();
      chk("frame_tick_40", 32'(frame_tick), 32'd1);
      tick();
      chk("frame_tick_pulse", 32'(frame_tick), 32'd0);

      // Single frame {D,N,R,BLANK}; shown in frames 3 and 4
      push_digits(f1, 4);
      push_digits(f1, 4);
      wait_k(85);
      send(f1);
      chk("ready_drop", 32'(char_ready), 32'd0);
      wait_k(119);
      chk("ready_low_pre_boundary", 32'(char_ready), 32'd0);
      tick();
      chk("ready_after_boundary", 32'(char_ready), 32'd1);
      chk("frame_tick_120", 32'(frame_tick), 32'd1);
      wait_k(152);
      chk("digit3_an", 32'(an), 32'h07);
      chk("digit3_seg_D", 32'(seg), 32'(C_D));

      // Second frame held while the slot is full
      push_digits(fa, 4);
      push_digits(fb, 4);
      wait_k(165);
      send(fa);
      chk("hold_first_ready", 32'(char_ready), 32'd0);
      send(fb);
      chk("hold_accept_cycle", 32'(k), 32'd201);
      chk("hold_ready_low", 32'(char_ready), 32'd0);
      wait_k(240);
      chk("hold_ready_back", 32'(char_ready), 32'd1);

      // Valid exactly on the boundary with the slot empty
      push_digits(fc, 4);
      push_digits(fc, 3);
      wait_k(279);
      char_in    = fc;
      char_valid = 1'b1;
      tick();
      char_valid = 1'b0;
      chk("bypass_ready", 32'(char_ready), 32'd1);
      chk("bypass_frame_tick", 32'(frame_tick), 32'd1);
      tick();
      chk("bypass_ready_stays", 32'(char_ready), 32'd1);
      wait_k(282);
      chk("bypass_digit0_seg", 32'(seg), 32'(fc[6:0]));

      // Drop en in the middle of digit 2
      wait_k(345);
      en = 1'b0;
      tick();
      chk("dark_an", 32'(an), 32'h0F);
      chk("dark_seg", 32'(seg), 32'h7F);
      tick(); tick(); tick();
      push_digits(fc, 3);
      enable();
      tick();
      chk("reen_blank0", 32'(an), 32'h0F);
      tick();
      chk("reen_blank1", 32'(an), 32'h0F);
      tick();
      chk("reen_digit0_an", 32'(an), 32'h0E);
      chk("reen_digit0_seg", 32'(seg), 32'(fc[6:0]));

      // Reset mid-scan with a frame pending
      wait_k(5);
      send(fe);
      chk("pend_before_rst", 32'(char_ready), 32'd0);
      wait_k(25);
      rst = 1'b1;
      tick();
      chk("mid_rst_an", 32'(an), 32'h0F);
      chk("mid_rst_seg", 32'(seg), 32'h7F);
      chk("mid_rst_frame_tick", 32'(frame_tick), 32'd0);
      chk("mid_rst_ready", 32'(char_ready), 32'd1);
      rst = 1'b0;
      en  = 1'b0;
      tick();
      push_digits(fblank, 4);
      push_digits(fblank, 4);
      enable();
      wait_k(81);
      chk("post_rst_ready", 32'(char_ready), 32'd1);
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
